pvc_allocator: RTL and testbench
================================

PVC_ALLOCATOR -- requirements
Module: pvc_allocator

Interface
REQ-001 Parameter NUM_IN, default 5, number of requesting input VCs.
REQ-002 Parameter NUM_OUT, default 5, number of output VCs allocated.
REQ-003 Parameter ARB_MODE, default 0, arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 vc_req  input  NUM_IN*NUM_OUT  bit [i*NUM_OUT+o] = input VC i requests output VC o; any subset allowed.
REQ-007 out_vc_release  input  NUM_OUT  one-cycle pulse per output VC: tail flit sent, free the VC.
REQ-008 vc_grant  output  NUM_IN  combinational pulse: input VC i allocated this cycle.
REQ-009 vc_sel  output  NUM_IN*NUM_OUT  combinational one-hot per input: the output VC granted; all zero when vc_grant[i]=0.
REQ-010 out_vc_busy  output  NUM_OUT  registered: output VC owned.
REQ-011 out_vc_owner  output  NUM_OUT*IDW  registered owner index per output VC, IDW = max(1,clog2(NUM_IN)); 0 when not busy.
REQ-012 in_vc_alloc  output  NUM_IN  registered: input VC currently holds an output VC.

Function
REQ-013 Eligible request: vc_req[i][o] & ~out_vc_busy[o] & ~in_vc_alloc[i]; all other requests ignored.
REQ-014 Stage 1 (per input): select one eligible output VC via per-input arbiter over NUM_OUT.
REQ-015 Stage 2 (per output): among inputs whose stage-1 choice is o, select one via per-output arbiter over NUM_IN.
REQ-016 Grant is combinational, zero-cycle latency: vc_grant/vc_sel valid in same cycle as eligible request.
REQ-017 At most one grant per input and per output VC per cycle; vc_sel rows one-hot or zero.
REQ-018 On grant (i,o) at edge: out_vc_busy[o]<=1, out_vc_owner[o]<=i, in_vc_alloc[i]<=1.
REQ-019 Round-robin pointers: stage-1 pointer of i and stage-2 pointer of o advance to (winner+1) mod N only on final grant; unchanged otherwise.
REQ-020 Stage-1 losers in stage 2 keep their pointer; retry next cycle.
REQ-021 ARB_MODE=1: pointers held at 0, lowest index always wins.
REQ-022 Release of o at edge: out_vc_busy[o]<=0, owner<=0, in_vc_alloc[owner]<=0.
REQ-023 Release of o and request for o same cycle: o not grantable that cycle (busy still 1); grantable next cycle.
REQ-024 Release of a non-busy VC: ignored, no state change.
REQ-025 Release of o and grant of different VC o' same cycle: both applied at same edge.
REQ-026 Input that released and requests in same cycle: in_vc_alloc still 1, no grant until next cycle.
REQ-027 Requests held after grant are masked by in_vc_alloc; no double allocation.
REQ-028 Pointer wrap: winner NUM-1 -> pointer 0.

Reset
REQ-029 rstn low: out_vc_busy=0, out_vc_owner=0, in_vc_alloc=0, all pointers=0, asynchronously.
REQ-030 During reset vc_grant and vc_sel are 0.
REQ-031 Reset mid-allocation discards all ownership; first cycle after release of reset behaves as fresh start.

Structure
REQ-032 Shared package holds ARB_MODE encodings (ARB_RR, ARB_FIXED) and the IDW width function.
REQ-033 One sub-module rr_arbiter (parameter LEN, MODE; request, grant, update, pointer state) instantiated NUM_IN + NUM_OUT times.
REQ-034 Ownership state (busy, owner, alloc) lives in the top module.

Verification
REQ-035 Defaults; inputs 0,1,2 all request VC3 continuously, release VC3 each cycle after grant -> grants rotate 0,1,2,0.
REQ-036 Input 4 requests VCs {1,3}, input 2 requests VC1 same cycle -> both granted on different VCs, vc_sel one-hot, busy[1],busy[3] next cycle.
REQ-037 VC2 granted to input 1; next cycle release VC2 while input 0 requests VC2 -> no grant that cycle, grant to input 0 following cycle, owner[2]=0.
REQ-038 ARB_MODE=1, inputs 3 and 1 request VC0 repeatedly with release -> input 1 always wins.
REQ-039 NUM_IN=8, NUM_OUT=2, all inputs request both VCs -> exactly two grants per allocation round, no input granted twice while in_vc_alloc=1.
REQ-040 Assert rstn low with 3 VCs busy -> busy, alloc, owner all 0 immediately; pending requests granted first cycle after reset release.

Source files
------------

// File: rtl/pvc_allocator_pkg.sv
// rtl/pvc_allocator_pkg.sv - shared arbitration encodings and width helper for the VC allocator
package pvc_allocator_pkg;

  localparam int ARB_RR    = 0;  // rotating priority
  localparam int ARB_FIXED = 1;  // lowest index always wins

  // Width of an index into n entries, never narrower than one bit.
  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - one-hot arbiter with rotating or fixed priority
// Ports:
//   clk, rstn  : clock, asynchronous active-low reset
//   req        : request vector (LEN bits)
//   update     : the grant was consumed; rotate priority past the winner
//   grant      : combinational one-hot grant, zero when no request
module rr_arbiter
  import pvc_allocator_pkg::*;
#(
  parameter int LEN  = 4,
  parameter int MODE = ARB_RR
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [LEN-1:0] req,
  input  logic           update,
  output logic [LEN-1:0] grant
);

  localparam int  PW     = (LEN > 1) ? $clog2(LEN) : 1;
  localparam bit  ROTATE = (MODE != ARB_FIXED);

  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic          found;
  int            d;
  int            best_d;

  // Winner is the requester at the smallest cyclic distance from ptr.
  always_comb begin
    found  = 1'b0;
    win    = '0;
    best_d = LEN;
    d      = 0;
    grant  = '0;
    for (int j = 0; j < LEN; j++) begin
      if (req[j]) begin
        d = (j >= int'(ptr)) ? (j - int'(ptr)) : (j + LEN - int'(ptr));
        if (d < best_d) begin
          best_d = d;
          win    = PW'(j);
          found  = 1'b1;
        end
      end
    end
    for (int j = 0; j < LEN; j++) begin
      grant[j] = found && (int'(win) == j);
    end
  end

  // In fixed mode the pointer never leaves 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr <= '0;
    end else if (update && ROTATE) begin
      ptr <= (int'(win) == LEN - 1) ? '0 : win + PW'(1);
    end
  end

endmodule

// File: rtl/pvc_allocator.sv
// rtl/pvc_allocator.sv - two-stage separable virtual-channel allocator with ownership tracking
// Ports:
//   clk, rstn       : clock, asynchronous active-low reset
//   vc_req          : bit [i*NUM_OUT+o] = input VC i wants output VC o
//   out_vc_release  : per output VC pulse freeing it (tail flit sent)
//   vc_grant        : combinational, input VC i allocated this cycle
//   vc_sel          : combinational one-hot row per input, granted output VC
//   out_vc_busy     : registered, output VC owned
//   out_vc_owner    : registered owner index per output VC (0 when free)
//   in_vc_alloc     : registered, input VC holds an output VC
module pvc_allocator
  import pvc_allocator_pkg::*;
#(
  parameter int   NUM_IN   = 5,
  parameter int   NUM_OUT  = 5,
  parameter int   ARB_MODE = ARB_RR,
  localparam int  IDW      = idw(NUM_IN)
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [NUM_IN*NUM_OUT-1:0]  vc_req,
  input  logic [NUM_OUT-1:0]         out_vc_release,
  output logic [NUM_IN-1:0]          vc_grant,
  output logic [NUM_IN*NUM_OUT-1:0]  vc_sel,
  output logic [NUM_OUT-1:0]         out_vc_busy,
  output logic [NUM_OUT*IDW-1:0]     out_vc_owner,
  output logic [NUM_IN-1:0]          in_vc_alloc
);

  logic [NUM_IN*NUM_OUT-1:0] s1_req;   // input-major
  logic [NUM_IN*NUM_OUT-1:0] s1_gnt;   // input-major
  logic [NUM_OUT*NUM_IN-1:0] s2_req;   // output-major
  logic [NUM_OUT*NUM_IN-1:0] s2_gnt;   // output-major
  logic [NUM_OUT-1:0]        s2_upd;

  logic [NUM_OUT-1:0]        busy_n;
  logic [NUM_OUT*IDW-1:0]    owner_n;
  logic [NUM_IN-1:0]         alloc_n;

  // A request counts only if the output is free and the input holds nothing.
  always_comb begin
    s1_req = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      s1_req[i*NUM_OUT +: NUM_OUT] = vc_req[i*NUM_OUT +: NUM_OUT] & ~out_vc_busy
                                     & {NUM_OUT{~in_vc_alloc[i]}};
    end
  end

  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_s1
    rr_arbiter #(.LEN(NUM_OUT), .MODE(ARB_MODE)) u_arb (
      .clk    (clk),
      .rstn   (rstn),
      .req    (s1_req[gi*NUM_OUT +: NUM_OUT]),
      .update (vc_grant[gi]),
      .grant  (s1_gnt[gi*NUM_OUT +: NUM_OUT])
    );
  end

  // Stage 2 sees, per output, the inputs whose stage-1 pick was that output.
  always_comb begin
    s2_req = '0;
    for (int o = 0; o < NUM_OUT; o++) begin
      for (int i = 0; i < NUM_IN; i++) begin
        s2_req[o*NUM_IN + i] = s1_gnt[i*NUM_OUT + o];
      end
    end
  end

  for (genvar go = 0; go < NUM_OUT; go++) begin : g_s2
    assign s2_upd[go] = rstn && (|s2_gnt[go*NUM_IN +: NUM_IN]);
    rr_arbiter #(.LEN(NUM_IN), .MODE(ARB_MODE)) u_arb (
      .clk    (clk),
      .rstn   (rstn),
      .req    (s2_req[go*NUM_IN +: NUM_IN]),
      .update (s2_upd[go]),
      .grant  (s2_gnt[go*NUM_IN +: NUM_IN])
    );
  end

  // Final grants are forced quiet while reset is held.
  always_comb begin
    vc_sel   = '0;
    vc_grant = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      for (int o = 0; o < NUM_OUT; o++) begin
        vc_sel[i*NUM_OUT + o] = rstn && s2_gnt[o*NUM_IN + i];
      end
      vc_grant[i] = |vc_sel[i*NUM_OUT +: NUM_OUT];
    end
  end

  // Releases and grants never touch the same output or input in one cycle:
  // a releasing output is still busy and its owner is still allocated.
  always_comb begin
    busy_n  = out_vc_busy;
    owner_n = out_vc_owner;
    alloc_n = in_vc_alloc;
    for (int o = 0; o < NUM_OUT; o++) begin
      if (out_vc_release[o] && out_vc_busy[o]) begin
        busy_n[o]                  = 1'b0;
        owner_n[o*IDW +: IDW]      = '0;
        alloc_n[out_vc_owner[o*IDW +: IDW]] = 1'b0;
      end
    end
    for (int i = 0; i < NUM_IN; i++) begin
      for (int o = 0; o < NUM_OUT; o++) begin
        if (vc_sel[i*NUM_OUT + o]) begin
          busy_n[o]             = 1'b1;
          owner_n[o*IDW +: IDW] = IDW'(i);
          alloc_n[i]            = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_vc_busy  <= '0;
      out_vc_owner <= '0;
      in_vc_alloc  <= '0;
    end else begin
      out_vc_busy  <= busy_n;
      out_vc_owner <= owner_n;
      in_vc_alloc  <= alloc_n;
    end
  end

endmodule

// File: tb/tb_pvc_allocator.sv
// tb/tb_pvc_allocator.sv - self-checking bench for pvc_allocator (default and 8x2 fixed-priority builds)
module tb_pvc_allocator;

  logic        clk;
  logic        rstn;

  // Instance A: defaults (5x5, round-robin)
  logic [24:0] req_a;
  logic [4:0]  rel_a;
  logic [4:0]  grant_a;
  logic [24:0] sel_a;
  logic [4:0]  busy_a;
  logic [14:0] owner_a;
  logic [4:0]  alloc_a;

  // Instance B: 8 inputs, 2 outputs, fixed priority
  logic [15:0] req_b;
  logic [1:0]  rel_b;
  logic [7:0]  grant_b;
  logic [15:0] sel_b;
  logic [1:0]  busy_b;
  logic [5:0]  owner_b;
  logic [7:0]  alloc_b;

  int n_tests = 0;
  int n_fail  = 0;

  pvc_allocator dut_a (
    .clk            (clk),
    .rstn           (rstn),
    .vc_req         (req_a),
    .out_vc_release (rel_a),
    .vc_grant       (grant_a),
    .vc_sel         (sel_a),
    .out_vc_busy    (busy_a),
    .out_vc_owner   (owner_a),
    .in_vc_alloc    (alloc_a)
  );

  pvc_allocator #(.NUM_IN(8), .NUM_OUT(2), .ARB_MODE(1)) dut_b (
    .clk            (clk),
    .rstn           (rstn),
    .vc_req         (req_b),
    .out_vc_release (rel_b),
    .vc_grant       (grant_b),
    .vc_sel         (sel_b),
    .out_vc_busy    (busy_b),
    .out_vc_owner   (owner_b),
    .in_vc_alloc    (alloc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: ownership tables and priority pointers per instance.
  int m_busy [2][8];
  int m_owner[2][8];
  int m_alloc[2][8];
  int m_p1   [2][8];
  int m_p2   [2][8];

  function automatic int ni_of(input int k); return (k == 0) ? 5 : 8; endfunction
  function automatic int no_of(input int k); return (k == 0) ? 5 : 2; endfunction

  task automatic model_reset(input int k);
    for (int j = 0; j < 8; j++) begin
      m_busy[k][j] = 0; m_owner[k][j] = 0; m_alloc[k][j] = 0;
      m_p1[k][j] = 0;   m_p2[k][j] = 0;
    end
  endtask

  // Each free input picks the first eligible output scanning cyclically from
  // its pointer; each output then accepts the first chooser scanning from its pointer.
  task automatic model_eval(input int k, input logic [63:0] req,
                            output logic [63:0] sel, output logic [63:0] gnt);
    int ni, no, o, i;
    int ch[8];
    bit done;
    ni = ni_of(k); no = no_of(k);
    sel = '0; gnt = '0;
    for (int x = 0; x < 8; x++) ch[x] = -1;
    for (int x = 0; x < ni; x++) begin
      if (m_alloc[k][x] == 0) begin
        for (int j = 0; j < no; j++) begin
          o = (m_p1[k][x] + j) % no;
          if (ch[x] < 0 && req[x*no + o] && m_busy[k][o] == 0) ch[x] = o;
        end
      end
    end
    for (int y = 0; y < no; y++) begin
      done = 0;
      for (int j = 0; j < ni; j++) begin
        i = (m_p2[k][y] + j) % ni;
        if (!done && ch[i] == y) begin
          sel[i*no + y] = 1'b1;
          gnt[i] = 1'b1;
          done = 1;
        end
      end
    end
  endtask

  task automatic model_step(input int k, input logic [63:0] rel, input logic [63:0] sel);
    int ni, no;
    ni = ni_of(k); no = no_of(k);
    for (int o = 0; o < no; o++) begin
      if (rel[o] && m_busy[k][o] != 0) begin
        m_alloc[k][m_owner[k][o]] = 0;
        m_busy[k][o] = 0;
        m_owner[k][o] = 0;
      end
    end
    for (int i = 0; i < ni; i++) begin
      for (int o = 0; o < no; o++) begin
        if (sel[i*no + o]) begin
          m_busy[k][o] = 1; m_owner[k][o] = i; m_alloc[k][i] = 1;
          if (k == 0) begin
            m_p1[k][i] = (o + 1) % no;
            m_p2[k][o] = (i + 1) % ni;
          end
        end
      end
    end
  endtask

  // Compare every cycle at the falling edge; then advance the model to the next rising edge.
  always @(negedge clk) begin : chk
    logic [63:0] es, eg, eb, ea, eo;
    for (int k = 0; k < 2; k++) begin
      if (!rstn) model_reset(k);
      eb = '0; ea = '0; eo = '0;
      for (int o = 0; o < no_of(k); o++) begin
        eb[o] = (m_busy[k][o] != 0);
        eo[o*3 +: 3] = 3'(m_owner[k][o]);
      end
      for (int i = 0; i < ni_of(k); i++) ea[i] = (m_alloc[k][i] != 0);
      if (k == 0) model_eval(0, 64'(req_a), es, eg);
      else        model_eval(1, 64'(req_b), es, eg);
      if (!rstn) begin es = '0; eg = '0; end
      if (k == 0) begin
        check("a_grant", 64'(grant_a), eg);
        check("a_sel",   64'(sel_a),   es);
        check("a_busy",  64'(busy_a),  eb);
        check("a_owner", 64'(owner_a), eo);
        check("a_alloc", 64'(alloc_a), ea);
        if (rstn) model_step(0, 64'(rel_a), es);
      end else begin
        check("b_grant", 64'(grant_b), eg);
        check("b_sel",   64'(sel_b),   es);
        check("b_busy",  64'(busy_b),  eb);
        check("b_owner", 64'(owner_b), eo);
        check("b_alloc", 64'(alloc_b), ea);
        if (rstn) model_step(1, 64'(rel_b), es);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    req_a = '0; rel_a = '0; req_b = '0; rel_b = '0;
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    int rot[4];
    rot = '{0, 1, 2, 0};
    rstn = 1'b0;
    req_a = '0; rel_a = '0; req_b = '0; rel_b = '0;
    tick();
    #1;
    check("reset_busy",  64'(busy_a),  64'd0);
    check("reset_grant", 64'(grant_a), 64'd0);
    tick();

    // Three inputs contend for VC3; each allocation is released next cycle.
    do_reset();
    req_a = (25'd1 << 3) | (25'd1 << 8) | (25'd1 << 13);
    for (int r = 0; r < 4; r++) begin
      rel_a = '0;
      #1 check("rr_rotate", 64'(grant_a), 64'd1 << rot[r]);
      tick();
      rel_a = 5'b01000;
      #1 check("rr_release_cycle", 64'(grant_a), 64'd0);
      tick();
    end
    rel_a = '0;

    // Input 4 wants {1,3}, input 2 wants 1: input 2 takes VC1, input 4 falls to VC3.
    do_reset();
    req_a = (25'd1 << 21) | (25'd1 << 23) | (25'd1 << 11);
    #1;
    check("two_in_c1_grant", 64'(grant_a), 64'h04);
    check("two_in_c1_sel",   64'(sel_a),   64'd1 << 11);
    tick(); #1;
    check("two_in_c2_grant", 64'(grant_a), 64'h10);
    check("two_in_c2_sel",   64'(sel_a),   64'd1 << 23);
    tick(); #1;
    check("two_in_busy",  64'(busy_a),  64'h0A);
    check("two_in_alloc", 64'(alloc_a), 64'h14);

    // Release and re-request of VC2 in the same cycle waits one cycle.
    do_reset();
    req_a = 25'd1 << 7;
    #1 check("rel_first_grant", 64'(grant_a), 64'h02);
    tick();
    req_a = 25'd1 << 2;
    rel_a = 5'b00100;
    #1 check("rel_same_cycle", 64'(grant_a), 64'd0);
    tick();
    rel_a = '0;
    #1;
    check("rel_next_grant", 64'(grant_a), 64'h01);
    check("rel_next_sel",   64'(sel_a),   64'h04);
    tick(); #1;
    check("rel_busy",  64'(busy_a),  64'h04);
    check("rel_owner", 64'(owner_a), 64'd0);
    check("rel_alloc", 64'(alloc_a), 64'h01);

    // Fixed priority: inputs 1 and 3 on VC0, input 1 always wins.
    do_reset();
    req_b = (16'd1 << 6) | (16'd1 << 2);
    for (int r = 0; r < 3; r++) begin
      rel_b = '0;
      #1 check("fixed_winner", 64'(grant_b), 64'h02);
      tick();
      rel_b = 2'b01;
      #1 check("fixed_release_cycle", 64'(grant_b), 64'd0);
      tick();
    end
    rel_b = '0;

    // Eight inputs on two VCs: one round gives exactly two grants.
    do_reset();
    req_b = 16'hFFFF;
    #1;
    check("8x2_c1_grant", 64'(grant_b), 64'h01);
    check("8x2_c1_sel",   64'(sel_b),   64'h0001);
    tick(); #1;
    check("8x2_c2_grant", 64'(grant_b), 64'h02);
    check("8x2_c2_sel",   64'(sel_b),   64'h0008);
    tick(); #1;
    check("8x2_c3_grant", 64'(grant_b), 64'd0);
    check("8x2_busy",     64'(busy_b),  64'h3);
    check("8x2_alloc",    64'(alloc_b), 64'h03);
    check("8x2_owner",    64'(owner_b), 64'h08);

    // Reset with three VCs busy, requests held across it.
    do_reset();
    req_a = 25'd1 | (25'd1 << 6) | (25'd1 << 12);
    #1 check("rst_pre_grant", 64'(grant_a), 64'h07);
    tick(); #1;
    check("rst_pre_busy", 64'(busy_a), 64'h07);
    rstn = 1'b0;
    #1;
    check("rst_busy",  64'(busy_a),  64'd0);
    check("rst_alloc", 64'(alloc_a), 64'd0);
    check("rst_owner", 64'(owner_a), 64'd0);
    check("rst_grant", 64'(grant_a), 64'd0);
    tick();
    rstn = 1'b1;
    #1 check("rst_after_grant", 64'(grant_a), 64'h07);
    tick();

    // Randomised traffic, with occasional resets, checked by the model.
    for (int c = 0; c < 3000; c++) begin
      rstn  = ($urandom_range(0, 299) != 0);
      req_a = 25'($urandom & $urandom);
      rel_a = 5'($urandom & $urandom);
      req_b = 16'($urandom & $urandom);
      rel_b = 2'($urandom);
      tick();
    end
    rstn = 1'b1;
    req_a = '0; rel_a = '0; req_b = '0; rel_b = '0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
